// File: rtl/ascon_decrypt_verify_if.sv
// Signal bundle for the Ascon-128 decrypt/verify back end.
// Ciphertext handshake: one block moves on each rising clk edge where
// ct_valid && ct_ready are both high. While ct_valid is high, the source
// holds ct_data/ct_last/ct_bytes stable until that edge. ct_ready never
// waits for ct_valid. pt_valid and done are single-cycle pulses with no
// back-pressure.
interface ascon_decrypt_verify_if;
   logic        start;
   logic [63:0] s_in0;
   logic [63:0] s_in1;
   logic [63:0] s_in2;
   logic [63:0] s_in3;
   logic [63:0] s_in4;
   logic [63:0] k0;
   logic [63:0] k1;
   logic [63:0] tag0;
   logic [63:0] tag1;
   logic        ct_valid;
   logic        ct_ready;
   logic [63:0] ct_data;
   logic        ct_last;
   logic [2:0]  ct_bytes;
   logic        pt_valid;
   logic [63:0] pt_data;
   logic [3:0]  pt_bytes;
   logic        busy;
   logic        done;
   logic        tag_ok;
   logic [2:0]  fsm_state;

   modport master (
      output start, s_in0, s_in1, s_in2, s_in3, s_in4, k0, k1, tag0, tag1,
             ct_valid, ct_data, ct_last, ct_bytes,
      input  ct_ready, pt_valid, pt_data, pt_bytes, busy, done, tag_ok, fsm_state
   );

   modport slave (
      input  start, s_in0, s_in1, s_in2, s_in3, s_in4, k0, k1, tag0, tag1,
             ct_valid, ct_data, ct_last, ct_bytes,
      output ct_ready, pt_valid, pt_data, pt_bytes, busy, done, tag_ok, fsm_state
   );
endinterface

// File: rtl/ascon_decrypt_verify.sv
// Ascon-128 decryption back end: takes the post-AD state, decrypts 64-bit
// ciphertext blocks (one permutation round per cycle) and checks the tag.
// fsm_state exposes the controller state for observation.
module ascon_decrypt_verify #(
   parameter int RATE_BYTES = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   ascon_decrypt_verify_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ABSORB = 3'd1;
   localparam logic [2:0] S_PERM6  = 3'd2;
   localparam logic [2:0] S_FINAL  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [3:0] PT_FULL  = 4'(RATE_BYTES);
   localparam logic [3:0] LAST_RND = 4'd11;

   logic [2:0]   state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [63:0]  x0_q, x0_d;
   logic [63:0]  x1_q, x1_d;
   logic [63:0]  x2_q, x2_d;
   logic [63:0]  x3_q, x3_d;
   logic [63:0]  x4_q, x4_d;
   logic [63:0]  k0_q, k0_d;
   logic [63:0]  k1_q, k1_d;
   logic [63:0]  t0_q, t0_d;
   logic [63:0]  t1_q, t1_d;
   logic         pt_valid_q, pt_valid_d;
   logic [63:0]  pt_data_q, pt_data_d;
   logic [3:0]   pt_bytes_q, pt_bytes_d;
   logic         tag_ok_q, tag_ok_d;

   logic         ct_ready;
   logic [319:0] rnd_out;
   logic [63:0]  keep_mask;
   logic [63:0]  pad_bits;

   function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion.
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
      logic [3:0]  rc_hi;
      logic [63:0] a0, a1, a2, a3, a4;
      logic [63:0] b0, b1, b2, b3, b4;
      logic [63:0] c0, c1, c2, c3, c4;
      rc_hi = 4'hF - idx;
      a0 = s[319:256];
      a1 = s[255:192];
      a2 = s[191:128] ^ {56'h0, rc_hi, idx};
      a3 = s[127:64];
      a4 = s[63:0];
      a0 = a0 ^ a4;
      a4 = a4 ^ a3;
      a2 = a2 ^ a1;
      b0 = a0 ^ (~a1 & a2);
      b1 = a1 ^ (~a2 & a3);
      b2 = a2 ^ (~a3 & a4);
      b3 = a3 ^ (~a4 & a0);
      b4 = a4 ^ (~a0 & a1);
      b1 = b1 ^ b0;
      b0 = b0 ^ b4;
      b3 = b3 ^ b2;
      b2 = ~b2;
      c0 = b0 ^ rotr(b0, 19) ^ rotr(b0, 28);
      c1 = b1 ^ rotr(b1, 61) ^ rotr(b1, 39);
      c2 = b2 ^ rotr(b2, 1)  ^ rotr(b2, 6);
      c3 = b3 ^ rotr(b3, 10) ^ rotr(b3, 17);
      c4 = b4 ^ rotr(b4, 7)  ^ rotr(b4, 41);
      return {c0, c1, c2, c3, c4};
   endfunction

   assign ct_ready = (state_q == S_ABSORB);
   assign rnd_out  = ascon_round({x0_q, x1_q, x2_q, x3_q, x4_q}, round_q);

   // Byte masks for the final block: keep the top ct_bytes bytes, pad at byte ct_bytes.
   always_comb begin
      keep_mask = '0;
      pad_bits  = '0;
      for (int b = 0; b < 8; b++) begin
         if (b < int'(bus.ct_bytes)) keep_mask[63 - 8*b -: 8] = 8'hFF;
         if (b == int'(bus.ct_bytes)) pad_bits[63 - 8*b -: 8] = 8'h80;
      end
   end

   // Controller and datapath next-state.
   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      x0_d       = x0_q;
      x1_d       = x1_q;
      x2_d       = x2_q;
      x3_d       = x3_q;
      x4_d       = x4_q;
      k0_d       = k0_q;
      k1_d       = k1_q;
      t0_d       = t0_q;
      t1_d       = t1_q;
      pt_valid_d = 1'b0;
      pt_data_d  = pt_data_q;
      pt_bytes_d = pt_bytes_q;
      tag_ok_d   = tag_ok_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               x0_d     = bus.s_in0;
               x1_d     = bus.s_in1;
               x2_d     = bus.s_in2;
               x3_d     = bus.s_in3;
               x4_d     = bus.s_in4 ^ 64'h1;
               k0_d     = bus.k0;
               k1_d     = bus.k1;
               t0_d     = bus.tag0;
               t1_d     = bus.tag1;
               tag_ok_d = 1'b0;
               state_d  = S_ABSORB;
            end
         end
         S_ABSORB: begin
            if (bus.ct_valid && ct_ready) begin
               pt_valid_d = 1'b1;
               if (!bus.ct_last) begin
                  pt_data_d  = x0_q ^ bus.ct_data;
                  pt_bytes_d = PT_FULL;
                  x0_d       = bus.ct_data;
                  round_d    = 4'd6;
                  state_d    = S_PERM6;
               end else begin
                  pt_data_d  = (x0_q ^ bus.ct_data) & keep_mask;
                  pt_bytes_d = {1'b0, bus.ct_bytes};
                  x0_d       = ((bus.ct_data & keep_mask) | (x0_q & ~keep_mask)) ^ pad_bits;
                  x1_d       = x1_q ^ k0_q;
                  x2_d       = x2_q ^ k1_q;
                  round_d    = 4'd0;
                  state_d    = S_FINAL;
               end
            end
         end
         S_PERM6, S_FINAL: begin
            x0_d    = rnd_out[319:256];
            x1_d    = rnd_out[255:192];
            x2_d    = rnd_out[191:128];
            x3_d    = rnd_out[127:64];
            x4_d    = rnd_out[63:0];
            round_d = round_q + 4'd1;
            if (round_q == LAST_RND) begin
               if (state_q == S_PERM6) begin
                  state_d = S_ABSORB;
               end else begin
                  tag_ok_d = ((rnd_out[127:64] ^ k0_q) == t0_q) &&
                             ((rnd_out[63:0]   ^ k1_q) == t1_q);
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         round_q    <= '0;
         x0_q       <= '0;
         x1_q       <= '0;
         x2_q       <= '0;
         x3_q       <= '0;
         x4_q       <= '0;
         k0_q       <= '0;
         k1_q       <= '0;
         t0_q       <= '0;
         t1_q       <= '0;
         pt_valid_q <= 1'b0;
         pt_data_q  <= '0;
         pt_bytes_q <= '0;
         tag_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         x0_q       <= x0_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
         x3_q       <= x3_d;
         x4_q       <= x4_d;
         k0_q       <= k0_d;
         k1_q       <= k1_d;
         t0_q       <= t0_d;
         t1_q       <= t1_d;
         pt_valid_q <= pt_valid_d;
         pt_data_q  <= pt_data_d;
         pt_bytes_q <= pt_bytes_d;
         tag_ok_q   <= tag_ok_d;
      end
   end

   assign bus.ct_ready  = ct_ready;
   assign bus.pt_valid  = pt_valid_q;
   assign bus.pt_data   = pt_data_q;
   assign bus.pt_bytes  = pt_bytes_q;
   assign bus.busy      = (state_q == S_ABSORB) || (state_q == S_PERM6) || (state_q == S_FINAL);
   assign bus.done      = (state_q == S_DONE);
   assign bus.tag_ok    = tag_ok_q;
   assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_ascon_decrypt_verify.sv
// Bench for ascon_decrypt_verify: an Ascon-128 encryption model produces
// ciphertext and tag; the DUT must return the plaintext and accept the tag.
module tb_ascon_decrypt_verify;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ascon_decrypt_verify_if bus ();
   ascon_decrypt_verify dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_fail = 0;
   int accept_cnt = 0;
   int done_cnt = 0;

   logic [63:0] exp_q[$];
   logic [3:0]  exp_bytes_q[$];
   logic [63:0] mon_e;
   logic [3:0]  mon_eb;

   logic [63:0] m[5];
   logic [63:0] y[5];
   logic [63:0] key0, key1;
   logic [63:0] pt_blk[8];
   logic [63:0] ct_blk[8];
   logic [63:0] exp_t0, exp_t1;
   logic [63:0] MSB_FLIP = 64'h8000_0000_0000_0000;

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Reference permutation in the C-reference formulation, rounds 12-rounds..11.
   task automatic m_perm(input int rounds);
      logic [63:0] t[5];
      int ra[5];
      int rb[5];
      ra = '{19, 61, 1, 10, 7};
      rb = '{28, 39, 6, 17, 41};
      for (int r = 12 - rounds; r < 12; r++) begin
         m[2] = m[2] ^ 64'((15 - r) * 16 + r);
         m[0] ^= m[4];
         m[4] ^= m[3];
         m[2] ^= m[1];
         for (int j = 0; j < 5; j++) t[j] = ~m[j] & m[(j + 1) % 5];
         for (int j = 0; j < 5; j++) m[j] ^= t[(j + 1) % 5];
         m[1] ^= m[0];
         m[0] ^= m[4];
         m[3] ^= m[2];
         m[2] = ~m[2];
         for (int j = 0; j < 5; j++) m[j] = m[j] ^ rotr(m[j], ra[j]) ^ rotr(m[j], rb[j]);
      end
   endtask

   // Encrypt pt_blk[0..nfull-1] plus an l-byte final block starting from y.
   task automatic model_encrypt(input int nfull, input int l);
      logic [63:0] mask, pad;
      for (int i = 0; i < 5; i++) m[i] = y[i];
      m[4] ^= 64'h1;
      for (int b = 0; b < nfull; b++) begin
         m[0] ^= pt_blk[b];
         ct_blk[b] = m[0];
         m_perm(6);
      end
      mask = (l == 0) ? 64'h0 : ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * l));
      pad  = 64'h80 << (8 * (7 - l));
      pt_blk[nfull] = pt_blk[nfull] & mask;
      m[0] ^= pt_blk[nfull] | pad;
      ct_blk[nfull] = m[0] & mask;
      m[1] ^= key0;
      m[2] ^= key1;
      m_perm(12);
      exp_t0 = m[3] ^ key0;
      exp_t1 = m[4] ^ key1;
   endtask

   task automatic random_setup(input int nfull);
      for (int i = 0; i < 5; i++) y[i] = {$urandom, $urandom};
      key0 = {$urandom, $urandom};
      key1 = {$urandom, $urandom};
      for (int b = 0; b <= nfull; b++) pt_blk[b] = {$urandom, $urandom};
   endtask

   task automatic check_quiet(input string tag);
      check64({tag, "_ct_ready"}, 64'(bus.ct_ready), 64'h0);
      check64({tag, "_pt_valid"}, 64'(bus.pt_valid), 64'h0);
      check64({tag, "_pt_data"},  bus.pt_data, 64'h0);
      check64({tag, "_pt_bytes"}, 64'(bus.pt_bytes), 64'h0);
      check64({tag, "_busy"},     64'(bus.busy), 64'h0);
      check64({tag, "_done"},     64'(bus.done), 64'h0);
      check64({tag, "_tag_ok"},   64'(bus.tag_ok), 64'h0);
      check64({tag, "_state"},    64'(bus.fsm_state), 64'h0);
   endtask

   // Counting monitors and plaintext scoreboard, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.ct_valid === 1'b1 && bus.ct_ready === 1'b1) accept_cnt++;
         if (bus.done === 1'b1) done_cnt++;
         if (bus.pt_valid === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL pt_spurious observed=%h expected=none", bus.pt_data);
            end
            if (exp_q.size() != 0) begin
               mon_e  = exp_q.pop_front();
               mon_eb = exp_bytes_q.pop_front();
               check64("pt_data", bus.pt_data, mon_e);
               check64("pt_bytes", 64'(bus.pt_bytes), 64'(mon_eb));
            end
         end
      end
   end

   task automatic do_start();
      bus.start = 1'b1;
      bus.s_in0 = y[0];
      bus.s_in1 = y[1];
      bus.s_in2 = y[2];
      bus.s_in3 = y[3];
      bus.s_in4 = y[4];
      bus.k0    = key0;
      bus.k1    = key1;
      tick();
      bus.start = 1'b0;
      check64("start_to_ready", 64'(bus.ct_ready), 64'h1);
      check64("start_clears_tag_ok", 64'(bus.tag_ok), 64'h0);
   endtask

   task automatic send_block(input logic [63:0] c, input bit last, input int l,
                             input bit hold, input bit poke);
      int n;
      bus.ct_valid = 1'b1;
      bus.ct_data  = c;
      bus.ct_last  = last;
      bus.ct_bytes = 3'(l);
      n = 0;
      while (bus.ct_ready !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check64("accept_wait", 64'(bus.ct_ready), 64'h1);
      tick();
      if (!hold) bus.ct_valid = 1'b0;
      if (!last) begin
         for (int i = 1; i <= 6; i++) begin
            check64("perm6_ready_low", 64'(bus.ct_ready), 64'h0);
            if (poke) begin
               bus.start = (i == 3);
               bus.s_in0 = {$urandom, $urandom};
            end
            tick();
         end
         bus.start = 1'b0;
         check64("perm6_ready_back", 64'(bus.ct_ready), 64'h1);
      end else begin
         n = 1;
         while (bus.done !== 1'b1 && n < 40) begin
            if (poke) bus.start = (n == 5);
            tick();
            n++;
         end
         bus.start = 1'b0;
         check64("done_latency", 64'(n), 64'd13);
      end
   endtask

   task automatic run_msg(input int nfull, input int l, input bit bad_tag,
                          input bit bad_ct, input bit hold, input bit poke);
      int a0, d0;
      logic exp_ok;
      logic [63:0] flip;
      model_encrypt(nfull, l);
      bus.tag0 = exp_t0;
      bus.tag1 = bad_tag ? (exp_t1 ^ 64'h1) : exp_t1;
      if (bad_ct) ct_blk[nfull - 1] = ct_blk[nfull - 1] ^ MSB_FLIP;
      exp_ok = !(bad_tag || bad_ct);
      a0 = accept_cnt;
      d0 = done_cnt;
      do_start();
      for (int b = 0; b <= nfull; b++) begin
         flip = (bad_ct && b == nfull - 1) ? MSB_FLIP : 64'h0;
         exp_q.push_back(pt_blk[b] ^ flip);
         exp_bytes_q.push_back((b == nfull) ? 4'(l) : 4'd8);
         send_block(ct_blk[b], b == nfull, l, hold, poke);
      end
      check64("tag_ok", 64'(bus.tag_ok), 64'(exp_ok));
      check64("busy_at_done", 64'(bus.busy), 64'h0);
      tick();
      check64("done_one_cycle", 64'(bus.done), 64'h0);
      check64("tag_ok_hold", 64'(bus.tag_ok), 64'(exp_ok));
      if (hold) repeat (3) tick();
      bus.ct_valid = 1'b0;
      tick();
      check64("accept_count", 64'(accept_cnt - a0), 64'(nfull + 1));
      check64("done_count", 64'(done_cnt - d0), 64'h1);
   endtask

   initial begin
      int d0;
      logic [63:0] n0, n1;
      bus.start = 1'b0;
      bus.s_in0 = '0; bus.s_in1 = '0; bus.s_in2 = '0; bus.s_in3 = '0; bus.s_in4 = '0;
      bus.k0 = '0; bus.k1 = '0; bus.tag0 = '0; bus.tag1 = '0;
      bus.ct_valid = 1'b0; bus.ct_data = '0; bus.ct_last = 1'b0; bus.ct_bytes = '0;
      rst_n = 1'b0;
      repeat (3) tick();
      check_quiet("reset");
      rst_n = 1'b1;
      tick();
      check_quiet("post_reset");

      // Full block: x0=0123..., C=FFFF... gives FEDC..., then an empty final block.
      random_setup(1);
      y[0] = 64'h0123_4567_89AB_CDEF;
      pt_blk[0] = 64'hFEDC_BA98_7654_3210;
      run_msg(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Partial final block of 3 bytes: C=AABBCC00..., pt=AB9889...
      random_setup(0);
      y[0] = 64'h0123_4567_89AB_CDEF;
      pt_blk[0] = 64'hAB98_8900_0000_0000;
      run_msg(0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      // Known key/nonce: initialise, absorb one AD block plus padding, then decrypt.
      key0 = 64'h265F_1C12_888E_151A;
      key1 = 64'hC74F_26B3_0A8C_44B2;
      n0   = 64'h369C_801F_3AE8_D0EA;
      n1   = 64'h9BF3_67D5_8FD2_11FF;
      m[0] = 64'h8040_0C06_0000_0000; m[1] = key0; m[2] = key1; m[3] = n0; m[4] = n1;
      m_perm(12);
      m[3] ^= key0;
      m[4] ^= key1;
      m[0] ^= 64'h4153_434F_4E2D_4144;
      m_perm(6);
      m[0] ^= 64'h8000_0000_0000_0000;
      m_perm(6);
      for (int i = 0; i < 5; i++) y[i] = m[i];
      pt_blk[0] = 64'h0011_2233_4455_6677;
      pt_blk[1] = 64'h8899_AABB_CCDD_EEFF;
      pt_blk[2] = 64'h0;
      run_msg(2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_msg(2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_msg(2, 0, 1'b0, 1'b1, 1'b0, 1'b0);

      // ct_valid held high throughout, start re-pulsed while busy.
      random_setup(2);
      run_msg(2, 4, 1'b0, 1'b0, 1'b1, 1'b1);

      // Randomized messages.
      for (int r = 0; r < 5; r++) begin
         int nf, l;
         nf = $urandom_range(0, 3);
         l  = $urandom_range(0, 7);
         random_setup(nf);
         run_msg(nf, l, 1'b0, 1'b0, r[0], 1'b0);
      end

      // Reset in the middle of finalization.
      random_setup(0);
      model_encrypt(0, 5);
      bus.tag0 = exp_t0;
      bus.tag1 = exp_t1;
      do_start();
      exp_q.push_back(pt_blk[0]);
      exp_bytes_q.push_back(4'd5);
      bus.ct_valid = 1'b1;
      bus.ct_data  = ct_blk[0];
      bus.ct_last  = 1'b1;
      bus.ct_bytes = 3'd5;
      tick();
      bus.ct_valid = 1'b0;
      repeat (5) tick();
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check_quiet("rst_mid_final");
      tick();
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check64("rst_no_done", 64'(done_cnt - d0), 64'h0);
      check_quiet("rst_after");
      check64("exp_q_drained", 64'(exp_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
